// File: rtl/deck_manager_if.sv
// Command/response bundle between a deck_manager and the controller driving it.
interface deck_manager_if #(
   parameter int CARD_W    = 4,
   parameter int NUM_TYPES = 16,
   parameter int DEPTH     = 64
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                 cmd_valid;
   logic [1:0]           cmd;
   logic [NUM_TYPES-1:0] sel_sw;
   logic [CARD_W-1:0]    card_in;
   logic                 ready;
   logic [CARD_W-1:0]    card_out;
   logic                 card_valid;
   logic [CNT_W-1:0]     deck_count;
   logic [CNT_W-1:0]     discard_count;
   logic                 done;
   logic                 err;

   modport master (
      output cmd_valid, cmd, sel_sw, card_in,
      input  ready, card_out, card_valid, deck_count, discard_count, done, err
   );

   modport slave (
      input  cmd_valid, cmd, sel_sw, card_in,
      output ready, card_out, card_valid, deck_count, discard_count, done, err
   );
endinterface

// File: rtl/deck_manager.sv
// Card deck/discard manager: GAIN/DISCARD push onto discard, DRAW pops the deck,
// refilling it from discard with an LFSR-driven Fisher-Yates shuffle when empty.
module deck_manager #(
   parameter int          CARD_W    = 4,
   parameter int          NUM_TYPES = 16,
   parameter int          DEPTH     = 64,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input logic           clk,
   input logic           reset,
   deck_manager_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [15:0]   LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_SHUF, S_POP} state_t;
   typedef enum logic [1:0] {OP_GAIN, OP_DRAW, OP_DISCARD, OP_SHUFFLE} op_t;

   state_t            state;
   op_t               op;
   logic [CW-1:0]     shuf_i;
   logic              draw_pend;
   logic [15:0]       lfsr;
   logic [15:0]       lfsr_next;

   logic [CARD_W-1:0] deck_mem [DEPTH];
   logic [CARD_W-1:0] disc_mem [DEPTH];

   logic [CARD_W-1:0] sel_idx;
   logic [1:0]        sel_hits;
   logic              sel_onehot;
   logic              piles_full;
   logic [IW-1:0]     deck_top;
   logic [IW-1:0]     deck_push;
   logic [IW-1:0]     disc_top;
   logic [IW-1:0]     disc_push;
   logic [IW-1:0]     swap_i;
   logic [IW-1:0]     swap_j;
   logic [16+CW-1:0]  swap_prod;
   logic              disc_we;
   logic [CARD_W-1:0] disc_wdata;

   always_comb begin
      op       = op_t'(bus.cmd);
      sel_idx  = '0;
      sel_hits = '0;
      for (int unsigned k = 0; k < NUM_TYPES; k++) begin
         if (bus.sel_sw[k]) begin
            sel_idx = CARD_W'(k);
            if (sel_hits != 2'd2) sel_hits = sel_hits + 2'd1;
         end
      end
      sel_onehot = (sel_hits == 2'd1);
      piles_full = (bus.deck_count + bus.discard_count) == FULL;

      deck_top  = IW'(bus.deck_count - ONE);
      deck_push = IW'(bus.deck_count);
      disc_top  = IW'(bus.discard_count - ONE);
      disc_push = IW'(bus.discard_count);

      // j = floor(lfsr * (i+1) / 2^16) is always <= i, so no divider is needed
      swap_i    = IW'(shuf_i);
      swap_prod = (16 + CW)'(lfsr) * (16 + CW)'(shuf_i + ONE);
      swap_j    = IW'(swap_prod >> 16);

      lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);

      disc_we    = bus.ready && bus.cmd_valid && !piles_full &&
                   ((op == OP_GAIN && sel_onehot) || op == OP_DISCARD);
      disc_wdata = (op == OP_GAIN) ? sel_idx : bus.card_in;
   end

   // Pile storage carries no reset; the counts alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (disc_we) disc_mem[disc_push] <= disc_wdata;
      case (state)
         S_MOVE: deck_mem[deck_push] <= disc_mem[disc_top];
         S_SHUF: begin
            deck_mem[swap_i] <= deck_mem[swap_j];
            deck_mem[swap_j] <= deck_mem[swap_i];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= S_IDLE;
         shuf_i            <= '0;
         draw_pend         <= 1'b0;
         lfsr              <= SEED;
         bus.ready         <= 1'b1;
         bus.card_out      <= '0;
         bus.card_valid    <= 1'b0;
         bus.deck_count    <= '0;
         bus.discard_count <= '0;
         bus.done          <= 1'b0;
         bus.err           <= 1'b0;
      end else begin
         lfsr           <= lfsr_next;
         bus.card_valid <= 1'b0;
         bus.done       <= 1'b0;
         bus.err        <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.cmd_valid && bus.ready) begin
                  case (op)
                     OP_GAIN, OP_DISCARD: begin
                        if (piles_full || (op == OP_GAIN && !sel_onehot)) begin
                           bus.err <= 1'b1;
                        end else begin
                           bus.discard_count <= bus.discard_count + ONE;
                           bus.done          <= 1'b1;
                        end
                     end
                     OP_DRAW: begin
                        if (bus.deck_count != '0) begin
                           bus.card_out   <= deck_mem[deck_top];
                           bus.card_valid <= 1'b1;
                           bus.done       <= 1'b1;
                           bus.deck_count <= bus.deck_count - ONE;
                        end else if (bus.discard_count != '0) begin
                           draw_pend <= 1'b1;
                           bus.ready <= 1'b0;
                           state     <= S_MOVE;
                        end else begin
                           bus.err <= 1'b1;
                        end
                     end
                     OP_SHUFFLE: begin
                        draw_pend <= 1'b0;
                        if (bus.discard_count != '0) begin
                           bus.ready <= 1'b0;
                           state     <= S_MOVE;
                        end else if (bus.deck_count > ONE) begin
                           shuf_i    <= bus.deck_count - ONE;
                           bus.ready <= 1'b0;
                           state     <= S_SHUF;
                        end else begin
                           bus.done <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_MOVE: begin
               bus.deck_count    <= bus.deck_count + ONE;
               bus.discard_count <= bus.discard_count - ONE;
               if (bus.discard_count == ONE) begin
                  // Deck grows to deck_count+1; a single card needs no shuffling.
                  if (bus.deck_count != '0) begin
                     shuf_i <= bus.deck_count;
                     state  <= S_SHUF;
                  end else if (draw_pend) begin
                     state <= S_POP;
                  end else begin
                     bus.done  <= 1'b1;
                     bus.ready <= 1'b1;
                     state     <= S_IDLE;
                  end
               end
            end
            S_SHUF: begin
               shuf_i <= shuf_i - ONE;
               if (shuf_i == ONE) begin
                  if (draw_pend) begin
                     state <= S_POP;
                  end else begin
                     bus.done  <= 1'b1;
                     bus.ready <= 1'b1;
                     state     <= S_IDLE;
                  end
               end
            end
            S_POP: begin
               bus.card_out   <= deck_mem[deck_top];
               bus.card_valid <= 1'b1;
               bus.done       <= 1'b1;
               bus.deck_count <= bus.deck_count - ONE;
               bus.ready      <= 1'b1;
               state          <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_deck_manager.sv
// Bench for deck_manager: transaction-level pile model predicting every output cycle.
module tb_deck_manager;
   localparam int          CARD_W    = 4;
   localparam int          NUM_TYPES = 16;
   localparam int          DEPTH     = 64;
   localparam logic [15:0] SEED      = 16'hACE1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   deck_manager_if #(.CARD_W(CARD_W), .NUM_TYPES(NUM_TYPES), .DEPTH(DEPTH)) bus ();

   deck_manager #(
      .CARD_W(CARD_W), .NUM_TYPES(NUM_TYPES), .DEPTH(DEPTH), .SEED(SEED)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {
      bit ready; bit cv; int co; int dc; int xc; bit done; bit err;
   } snap_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          deck_q[$];
   int          disc_q[$];
   int          m_card_out;
   logic [15:0] m_lfsr;
   snap_t       exp_s;
   snap_t       exp_q[$];
   bit          chk_en = 1'b0;
   int          done_seen = 0, err_seen = 0, cv_seen = 0, ready_low_seen = 0;
   int          model_log[$];
   int          dut_log[$];

   function automatic void check(string name, int act, int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic snap_t mk(bit rdy, bit cv, bit dn, bit er);
      snap_t s;
      s.ready = rdy; s.cv = cv; s.co = m_card_out;
      s.dc = deck_q.size(); s.xc = disc_q.size();
      s.done = dn; s.err = er;
      return s;
   endfunction

   function automatic logic [15:0] lfsr_step(logic [15:0] x);
      return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
   endfunction

   // Whole refill/shuffle worked out at once; one expected snapshot per busy cycle.
   task automatic long_op(bit is_draw);
      logic [15:0] lf = m_lfsr;
      longint      prod;
      int          n, j, t;
      snap_t       s;
      exp_q.push_back(mk(0, 0, 0, 0));
      while (disc_q.size() > 0) begin
         lf = lfsr_step(lf);
         deck_q.push_back(disc_q.pop_back());
         exp_q.push_back(mk(0, 0, 0, 0));
      end
      n = deck_q.size();
      for (int i = n - 1; i >= 1; i--) begin
         lf   = lfsr_step(lf);
         prod = longint'(lf) * longint'(i + 1);
         j    = int'(prod >> 16);
         t = deck_q[i]; deck_q[i] = deck_q[j]; deck_q[j] = t;
         exp_q.push_back(mk(0, 0, 0, 0));
      end
      if (is_draw) begin
         m_card_out = deck_q.pop_back();
         exp_q.push_back(mk(1, 1, 1, 0));
      end else begin
         s = exp_q.pop_back();
         s.ready = 1'b1; s.done = 1'b1;
         exp_q.push_back(s);
      end
   endtask

   task automatic model_accept(int op, logic [15:0] sel, int cin);
      int total = deck_q.size() + disc_q.size();
      int idx = 0;
      case (op)
         0: begin
            if ($countones(sel) != 1 || total == DEPTH) exp_q.push_back(mk(1, 0, 0, 1));
            else begin
               for (int b = 0; b < NUM_TYPES; b++) if (sel[b]) idx = b;
               disc_q.push_back(idx);
               exp_q.push_back(mk(1, 0, 1, 0));
            end
         end
         2: begin
            if (total == DEPTH) exp_q.push_back(mk(1, 0, 0, 1));
            else begin
               disc_q.push_back(cin);
               exp_q.push_back(mk(1, 0, 1, 0));
            end
         end
         1: begin
            if (deck_q.size() > 0) begin
               m_card_out = deck_q.pop_back();
               exp_q.push_back(mk(1, 1, 1, 0));
            end else if (disc_q.size() > 0) long_op(1'b1);
            else exp_q.push_back(mk(1, 0, 0, 1));
         end
         default: begin
            if (disc_q.size() == 0 && deck_q.size() < 2) exp_q.push_back(mk(1, 0, 1, 0));
            else long_op(1'b0);
         end
      endcase
   endtask

   task automatic model_edge();
      if (!reset) return;
      if (exp_q.size() > 0) exp_s = exp_q.pop_front();
      else if (bus.cmd_valid) begin
         model_accept(int'(bus.cmd), bus.sel_sw, int'(bus.card_in));
         exp_s = exp_q.pop_front();
      end else exp_s = mk(1, 0, 0, 0);
      if (exp_s.cv) model_log.push_back(exp_s.co);
      m_lfsr = lfsr_step(m_lfsr);
   endtask

   task automatic model_reset();
      deck_q.delete(); disc_q.delete(); exp_q.delete();
      m_card_out = 0;
      m_lfsr     = SEED;
      exp_s      = mk(1, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("ready",         bus.ready,         exp_s.ready);
         check("card_valid",    bus.card_valid,    exp_s.cv);
         check("card_out",      bus.card_out,      exp_s.co);
         check("deck_count",    bus.deck_count,    exp_s.dc);
         check("discard_count", bus.discard_count, exp_s.xc);
         check("done",          bus.done,          exp_s.done);
         check("err",           bus.err,           exp_s.err);
         if (bus.done) done_seen++;
         if (bus.err) err_seen++;
         if (!bus.ready) ready_low_seen++;
         if (bus.card_valid) begin
            cv_seen++;
            dut_log.push_back(int'(bus.card_out));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic wait_idle();
      int budget = 1000;
      while (exp_q.size() > 0 && budget > 0) begin
         step();
         budget--;
      end
      check("idle_timeout", exp_q.size(), 0);
   endtask

   task automatic issue(int op, logic [15:0] sel, int cin);
      bus.cmd       = 2'(op);
      bus.sel_sw    = sel;
      bus.card_in   = 4'(cin);
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      wait_idle();
   endtask

   task automatic run_fixed();
      for (int k = 0; k < 10; k++) issue(0, 16'(1 << k), 0);
      repeat (6) issue(1, 16'h0, 0);
   endtask

   initial begin
      int d0, e0, c0, r;
      int run1[$];
      reset = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd = '0; bus.sel_sw = '0; bus.card_in = '0;
      model_reset();
      chk_en = 1'b1;
      step(); step();
      reset = 1'b1;
      check("rst_deck", bus.deck_count, 0);
      check("rst_disc", bus.discard_count, 0);
      check("rst_ready", bus.ready, 1);

      d0 = done_seen; e0 = err_seen;
      repeat (3) issue(0, 16'h0008, 0);
      check("gain3_disc", bus.discard_count, 3);
      check("gain3_done", done_seen - d0, 3);
      check("gain3_err", err_seen - e0, 0);
      check("gain3_model_code", disc_q[2], 3);

      e0 = err_seen;
      issue(0, 16'h0009, 0);
      check("gain_multi_err", err_seen - e0, 1);
      check("gain_multi_disc", bus.discard_count, 3);
      issue(0, 16'h0000, 0);
      check("gain_zero_err", err_seen - e0, 2);

      issue(0, 16'h0001, 0);
      issue(0, 16'h8000, 0);
      ready_low_seen = 0; c0 = cv_seen; dut_log.delete();
      issue(1, 16'h0, 0);
      check("draw_ready_low", ready_low_seen, 10);
      check("draw_cv_once", cv_seen - c0, 1);
      check("draw_deck", bus.deck_count, 4);
      check("draw_disc", bus.discard_count, 0);
      check("draw_code_in_set",
            int'(bus.card_out == 4'd3 || bus.card_out == 4'd0 || bus.card_out == 4'd15), 1);
      repeat (4) issue(1, 16'h0, 0);
      dut_log.sort();
      check("multiset_n", dut_log.size(), 5);
      if (dut_log.size() == 5) begin
         check("multiset_0", dut_log[0], 0);
         check("multiset_1", dut_log[1], 3);
         check("multiset_3", dut_log[3], 3);
         check("multiset_4", dut_log[4], 15);
      end

      do_reset();
      e0 = err_seen;
      issue(1, 16'h0, 0);
      check("draw_empty_err", err_seen - e0, 1);
      check("draw_empty_deck", bus.deck_count, 0);
      check("draw_empty_disc", bus.discard_count, 0);

      for (int k = 0; k < DEPTH; k++) issue(2, 16'h0, k % 16);
      e0 = err_seen;
      issue(2, 16'h0, 5);
      check("full_discard_err", err_seen - e0, 1);
      check("full_sum", bus.deck_count + bus.discard_count, 64);
      issue(0, 16'h0004, 0);
      check("full_gain_err", err_seen - e0, 2);
      issue(3, 16'h0, 0);
      check("full_shuffle_deck", bus.deck_count, 64);
      repeat (3) issue(1, 16'h0, 0);
      check("full_after_draws", bus.deck_count, 61);

      do_reset();
      for (int k = 0; k < 20; k++) issue(0, 16'(1 << (k % 16)), 0);
      bus.cmd = 2'd3; bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      repeat (30) step();
      do_reset();
      check("abort_deck", bus.deck_count, 0);
      check("abort_disc", bus.discard_count, 0);
      check("abort_ready", bus.ready, 1);
      d0 = done_seen;
      issue(3, 16'h0, 0);
      check("shuf_empty_done", done_seen - d0, 1);
      check("shuf_empty_done_now", bus.done, 1);

      do_reset();
      model_log.delete();
      run_fixed();
      run1 = model_log;
      do_reset();
      dut_log.delete();
      run_fixed();
      check("repeat_len", dut_log.size(), run1.size());
      for (int i = 0; i < dut_log.size() && i < run1.size(); i++)
         check("repeat_order", dut_log[i], run1[i]);

      do_reset();
      repeat (3000) begin
         r = $urandom_range(0, 9);
         bus.cmd = (r < 4) ? 2'd0 : (r < 6) ? 2'd2 : (r < 9) ? 2'd1 : 2'd3;
         r = $urandom_range(0, 9);
         bus.sel_sw = (r == 0) ? 16'h0 : (r == 1) ? 16'($urandom) :
                      16'(1 << $urandom_range(0, 15));
         bus.card_in   = 4'($urandom_range(0, 15));
         bus.cmd_valid = ($urandom_range(0, 9) < 7);
         step();
      end
      bus.cmd_valid = 1'b0;
      wait_idle();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
